// File: rtl/sdf_bf_stage32.sv
// Radix-2 DIF single-path delay-feedback butterfly stage for a 64-point FFT section.
// A DEPTH-deep feedback shift line pairs each sample with the one DEPTH positions later.
module sdf_bf_stage32 #(
   parameter int DW    = 24,
   parameter int DEPTH = 32,
   parameter int WFRAC = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] din_r,
   input  logic signed [DW-1:0] din_i,
   input  logic        [1:0]    state,
   input  logic signed [DW-1:0] w_r,
   input  logic signed [DW-1:0] w_i,
   output logic                 out_valid,
   output logic signed [DW-1:0] dout_r,
   output logic signed [DW-1:0] dout_i
);

   // Only product bits that survive the shift and the DW-bit truncation are formed;
   // the low PW bits of a wider product/sum are identical, so the result is exact.
   localparam int PW = DW + WFRAC;

   localparam logic [1:0] ST_BFLY = 2'd1;
   localparam logic [1:0] ST_TWID = 2'd2;

   logic                 run_reg;
   logic signed [DW-1:0] dl_r  [DEPTH];
   logic signed [DW-1:0] dl_i  [DEPTH];
   logic signed [DW-1:0] src_r [DEPTH];
   logic signed [DW-1:0] src_i [DEPTH];

   logic                 is_bfly;
   logic                 is_twid;
   logic                 step;
   logic signed [DW-1:0] x_r, x_i;
   logic signed [DW-1:0] head_r, head_i;
   logic signed [DW-1:0] sum_r, sum_i;
   logic signed [DW-1:0] push_r, push_i;
   logic signed [PW-1:0] hr_x, hi_x, wr_x, wi_x;
   logic signed [PW-1:0] tw_r, tw_i;
   logic signed [DW-1:0] dtw_r, dtw_i;

   assign is_bfly = (state == ST_BFLY);
   assign is_twid = (state == ST_TWID);
   // Once running, butterfly/twiddle phases keep stepping so a gap drains zeros.
   assign step    = in_valid | (run_reg & (is_bfly | is_twid));

   assign x_r    = in_valid ? din_r : '0;
   assign x_i    = in_valid ? din_i : '0;
   assign head_r = dl_r[DEPTH-1];
   assign head_i = dl_i[DEPTH-1];

   assign sum_r  = head_r + x_r;
   assign sum_i  = head_i + x_i;
   assign push_r = is_bfly ? (head_r - x_r) : x_r;
   assign push_i = is_bfly ? (head_i - x_i) : x_i;

   assign hr_x = {{WFRAC{head_r[DW-1]}}, head_r};
   assign hi_x = {{WFRAC{head_i[DW-1]}}, head_i};
   assign wr_x = {{WFRAC{w_r[DW-1]}}, w_r};
   assign wi_x = {{WFRAC{w_i[DW-1]}}, w_i};

   assign tw_r  = hr_x * wr_x - hi_x * wi_x;
   assign tw_i  = hr_x * wi_x + hi_x * wr_x;
   assign dtw_r = DW'(tw_r >>> WFRAC);
   assign dtw_i = DW'(tw_i >>> WFRAC);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dl
      if (gi == 0) begin : g_in
         assign src_r[gi] = push_r;
         assign src_i[gi] = push_i;
      end else begin : g_tap
         assign src_r[gi] = dl_r[gi-1];
         assign src_i[gi] = dl_i[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dl_r[gi] <= '0;
            dl_i[gi] <= '0;
         end else if (step) begin
            dl_r[gi] <= src_r[gi];
            dl_i[gi] <= src_i[gi];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_reg   <= 1'b0;
         out_valid <= 1'b0;
         dout_r    <= '0;
         dout_i    <= '0;
      end else begin
         run_reg   <= run_reg | in_valid;
         out_valid <= step & (is_bfly | is_twid);
         if (step && is_bfly) begin
            dout_r <= sum_r;
            dout_i <= sum_i;
         end else if (step && is_twid) begin
            dout_r <= dtw_r;
            dout_i <= dtw_i;
         end
      end
   end

endmodule

// File: tb/tb_sdf_bf_stage32.sv
// Directed bench for sdf_bf_stage32: per-cycle vector table built from a frame-level
// reference (sum = x[k]+x[k+32], diff = (x[k]-x[k+32])*W^k) plus hand-computed spot values.
module tb_sdf_bf_stage32;

   typedef struct {
      logic               vld;
      logic signed [23:0] dr;
      logic signed [23:0] di;
      logic [1:0]         st;
      logic signed [23:0] wr;
      logic signed [23:0] wi;
      logic               ev;
      logic signed [23:0] er;
      logic signed [23:0] ei;
   } vec_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [23:0] din_r = '0;
   logic signed [23:0] din_i = '0;
   logic [1:0]         state = 2'd0;
   logic signed [23:0] w_r = '0;
   logic signed [23:0] w_i = '0;
   logic               out_valid;
   logic signed [23:0] dout_r;
   logic signed [23:0] dout_i;

   int n_cmp = 0;
   int n_bad = 0;

   int                 c_cos [17];
   logic signed [23:0] tw_r_t [32];
   logic signed [23:0] tw_i_t [32];
   logic signed [23:0] smp_r [128];
   logic signed [23:0] smp_i [128];
   logic               smp_v [128];
   logic signed [23:0] cap_r [200];
   logic signed [23:0] cap_i [200];
   vec_t               vecs [$];

   sdf_bf_stage32 #(.DW(24), .DEPTH(32), .WFRAC(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .din_r     (din_r),
      .din_i     (din_i),
      .state     (state),
      .w_r       (w_r),
      .w_i       (w_i),
      .out_valid (out_valid),
      .dout_r    (dout_r),
      .dout_i    (dout_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s idx=%0d got=%0d want=%0d", name, idx, act, exp);
      end
   endtask

   task automatic spot(input string name, input int idx, input int er, input int ei);
      check({name, "_r"}, idx, longint'(cap_r[idx]), longint'(er));
      check({name, "_i"}, idx, longint'(cap_i[idx]), longint'(ei));
   endtask

   function automatic logic signed [23:0] xr(input int n);
      return smp_v[n] ? smp_r[n] : 24'sd0;
   endfunction

   function automatic logic signed [23:0] xi(input int n);
      return smp_v[n] ? smp_i[n] : 24'sd0;
   endfunction

   task automatic clear_samples();
      for (int n = 0; n < 128; n++) begin
         smp_r[n] = '0;
         smp_i[n] = '0;
         smp_v[n] = 1'b1;
      end
   endtask

   // nf back-to-back frames followed by one drain block of twiddled differences.
   task automatic build(input int nf);
      vec_t v;
      int b, k, f;
      logic signed [23:0] a_r, a_i, b_r, b_i, d_r, d_i;
      longint pr, pi;
      vecs.delete();
      for (int c = 0; c < 64 * nf + 32; c++) begin
         b = c / 32;
         k = c % 32;
         v.st  = (b == 0) ? 2'd0 : ((b % 2 == 1) ? 2'd1 : 2'd2);
         v.vld = (c < 64 * nf) ? smp_v[c] : 1'b0;
         v.dr  = (c < 64 * nf) ? smp_r[c] : 24'sd5;
         v.di  = (c < 64 * nf) ? smp_i[c] : -24'sd7;
         v.wr  = tw_r_t[k];
         v.wi  = tw_i_t[k];
         if (b == 0) begin
            v.ev = 1'b0;
            v.er = '0;
            v.ei = '0;
         end else begin
            f   = (b - 1) / 2;
            a_r = xr(64 * f + k);
            a_i = xi(64 * f + k);
            b_r = xr(64 * f + 32 + k);
            b_i = xi(64 * f + 32 + k);
            v.ev = 1'b1;
            if (b % 2 == 1) begin
               v.er = a_r + b_r;
               v.ei = a_i + b_i;
            end else begin
               d_r = a_r - b_r;
               d_i = a_i - b_i;
               pr = longint'(d_r) * longint'(v.wr) - longint'(d_i) * longint'(v.wi);
               pi = longint'(d_r) * longint'(v.wi) + longint'(d_i) * longint'(v.wr);
               pr = pr >>> 8;
               pi = pi >>> 8;
               v.er = pr[23:0];
               v.ei = pi[23:0];
            end
         end
         vecs.push_back(v);
      end
   endtask

   task automatic run_vecs(input int limit);
      vec_t v;
      for (int i = 0; i < limit; i++) begin
         v = vecs[i];
         in_valid = v.vld;
         din_r    = v.dr;
         din_i    = v.di;
         state    = v.st;
         w_r      = v.wr;
         w_i      = v.wi;
         @(posedge clk);
         #1;
         cap_r[i] = dout_r;
         cap_i[i] = dout_i;
         $display("txn %0d st=%0d v=%0d din=%0d,%0d ov=%0d dout=%0d,%0d",
                  i, v.st, v.vld, v.dr, v.di, out_valid, dout_r, dout_i);
         check("out_valid", i, longint'(out_valid), longint'(v.ev));
         check("dout_r", i, longint'(dout_r), longint'(v.er));
         check("dout_i", i, longint'(dout_i), longint'(v.ei));
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      state    = 2'd0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      c_cos = '{256, 255, 251, 245, 237, 226, 213, 198, 181, 162, 142, 121, 98, 74, 50, 25, 0};
      for (int k = 0; k < 32; k++) begin
         tw_r_t[k] = 24'(k <= 16 ? c_cos[k] : -c_cos[32 - k]);
         tw_i_t[k] = 24'(-(k <= 16 ? c_cos[16 - k] : c_cos[k - 16]));
      end

      // Ramp, interrupted by an asynchronous reset mid-butterfly.
      clear_samples();
      for (int n = 0; n < 64; n++) smp_r[n] = 24'(n);
      do_reset();
      build(1);
      run_vecs(40);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", 0, longint'(out_valid), 0);
      check("rst_dout_r", 0, longint'(dout_r), 0);
      check("rst_dout_i", 0, longint'(dout_i), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Constant 100+0j: its first 32 fill cycles also confirm no output after the reset.
      clear_samples();
      for (int n = 0; n < 64; n++) smp_r[n] = 24'sd100;
      build(1);
      run_vecs(vecs.size());
      spot("const_sum", 32, 200, 0);
      spot("const_sum_last", 63, 200, 0);
      spot("const_diff", 64, 0, 0);

      // Full ramp.
      clear_samples();
      for (int n = 0; n < 64; n++) smp_r[n] = 24'(n);
      do_reset();
      build(1);
      run_vecs(vecs.size());
      spot("ramp_sum0", 32, 32, 0);
      spot("ramp_sum31", 63, 94, 0);
      spot("ramp_diff0", 64, -32, 0);
      spot("ramp_diff8", 72, -23, 22);
      spot("ramp_diff16", 80, 0, 32);

      // Imaginary-only path.
      clear_samples();
      for (int n = 0; n < 32; n++) smp_i[n] = 24'sd64;
      do_reset();
      build(1);
      run_vecs(vecs.size());
      spot("imag_sum8", 40, 0, 64);
      spot("imag_diff8", 72, 45, 45);

      // Two's-complement wrap on the sum.
      clear_samples();
      smp_r[0]  = 24'sd8388607;
      smp_r[32] = 24'sd8388607;
      do_reset();
      build(1);
      run_vecs(vecs.size());
      spot("wrap_sum0", 32, -2, 0);
      spot("wrap_diff0", 64, 0, 0);

      // Two back-to-back random frames, 3-cycle gap in the second butterfly phase.
      clear_samples();
      for (int n = 0; n < 128; n++) begin
         smp_r[n] = 24'(int'($urandom_range(0, 2097151)) - 1048576);
         smp_i[n] = 24'(int'($urandom_range(0, 2097151)) - 1048576);
      end
      for (int n = 100; n < 103; n++) smp_v[n] = 1'b0;
      do_reset();
      build(2);
      run_vecs(vecs.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
